// File: rtl/elevator_sequencer.sv
// Directional-sweep elevator car controller producing the 10-bit status word E.
// Optional emergency stop input is compiled in when ELEV_ESTOP_EN is defined.
module elevator_sequencer #(
  parameter int NUM_FLOORS   = 8,
  parameter int MID_FLOOR    = 4,
  parameter int FLOOR_CYCLES = 4,
  parameter int DOOR_CYCLES  = 3,
  parameter int MAX_PENDING  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req,
`ifdef ELEV_ESTOP_EN
  input  logic                  estop,
`endif
  output logic [9:0]            E,
  output logic [3:0]            floor,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam int TMAX = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  localparam logic [9:0] E_HANDOFF = 10'h140;
  localparam logic [9:0] E_DONE    = 10'h000;
  localparam logic [9:0] E_MIDDLE  = 10'h0F0;
  localparam logic [9:0] E_ESTOP   = 10'h3FF;

  logic [1:0]            r_state;
  logic                  r_dir;
  logic [3:0]            r_floor;
  logic [TW-1:0]         r_timer;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [9:0]            r_e;

  logic                  w_estop;
  logic [NUM_FLOORS-1:0] w_onehot;
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;
  logic                  w_here;
  logic [NUM_FLOORS-1:0] w_step_onehot;
  logic [NUM_FLOORS-1:0] w_ahead;

  logic [1:0]            w_state_nx;
  logic                  w_dir_nx;
  logic [3:0]            w_floor_nx;
  logic [TW-1:0]         w_timer_nx;
  logic [NUM_FLOORS-1:0] w_clear;
  logic [NUM_FLOORS-1:0] w_absorb;
  logic [NUM_FLOORS-1:0] w_new;
  logic [NUM_FLOORS-1:0] w_accept;
  logic                  w_drop;
  int                    w_count;
  logic [NUM_FLOORS-1:0] w_pending_nx;
  logic [9:0]            w_e_nx;

`ifdef ELEV_ESTOP_EN
  assign w_estop = estop;
`else
  assign w_estop = 1'b0;
`endif

  function automatic int popcount(input logic [NUM_FLOORS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  // Floor masks: the "<= floor" mask wraps to all-ones at the top floor, which is what we want.
  always_comb begin
    w_onehot = ONE << r_floor;
    w_above  = r_pending & ~((w_onehot << 1) - ONE);
    w_below  = r_pending & (w_onehot - ONE);
    w_here   = |(r_pending & w_onehot);
    w_step_onehot = r_dir ? (w_onehot << 1) : (w_onehot >> 1);
    if (r_dir) begin
      w_ahead = r_pending & ~((w_step_onehot << 1) - ONE);
    end else begin
      w_ahead = r_pending & (w_step_onehot - ONE);
    end
  end

  // Car FSM: all decisions look at the registered pending set.
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_floor_nx = r_floor;
    w_timer_nx = r_timer;
    w_clear    = '0;
    if (!w_estop) begin
      case (r_state)
        S_IDLE: begin
          if (w_here) begin
            w_state_nx = S_DOOR;
            w_clear    = w_onehot;
            w_timer_nx = TW'(DOOR_CYCLES);
          end else if (|r_pending) begin
            w_dir_nx   = (|w_above) && (r_dir || !(|w_below));
            w_state_nx = S_MOVE;
            w_timer_nx = TW'(FLOOR_CYCLES);
          end
        end
        S_MOVE: begin
          if (r_timer > TW'(1)) begin
            w_timer_nx = r_timer - TW'(1);
          end else begin
            w_floor_nx = r_dir ? (r_floor + 4'd1) : (r_floor - 4'd1);
            if (|(r_pending & w_step_onehot)) begin
              w_state_nx = S_DOOR;
              w_clear    = w_step_onehot;
              w_timer_nx = TW'(DOOR_CYCLES);
            end else if (|w_ahead) begin
              w_timer_nx = TW'(FLOOR_CYCLES);
            end else begin
              w_state_nx = S_IDLE;
              w_timer_nx = '0;
            end
          end
        end
        S_DOOR: begin
          if (|(req & w_onehot)) begin
            w_timer_nx = TW'(DOOR_CYCLES);
          end else if (r_timer > TW'(1)) begin
            w_timer_nx = r_timer - TW'(1);
          end else begin
            w_state_nx = S_IDLE;
            w_timer_nx = '0;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_timer_nx = '0;
        end
      endcase
    end
  end

  // Request latch: a call for the open-door floor is absorbed; capacity fills lowest floors first.
  always_comb begin
    w_absorb = (r_state == S_DOOR) ? w_onehot : '0;
    w_new    = req & ~r_pending & ~w_absorb & ~w_clear;
    w_accept = '0;
    w_drop   = 1'b0;
    w_count  = popcount(r_pending);
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_new[i]) begin
        if (w_count < MAX_PENDING) begin
          w_accept[i] = 1'b1;
          w_count     = w_count + 1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    w_pending_nx = (r_pending & ~w_clear) | w_accept;
  end

  // Status word reflects the state being entered on this edge.
  always_comb begin
    if (w_estop) begin
      w_e_nx = E_ESTOP;
    end else if (w_drop) begin
      w_e_nx = E_HANDOFF;
    end else if ((w_state_nx == S_IDLE) && (w_pending_nx == '0)) begin
      w_e_nx = E_DONE;
    end else if ((w_state_nx == S_MOVE) && (w_floor_nx == 4'(MID_FLOOR))) begin
      w_e_nx = E_MIDDLE;
    end else begin
      w_e_nx = {1'b1, 1'b0, w_dir_nx, (w_state_nx == S_DOOR), 2'b00, w_floor_nx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b1;
      r_floor   <= '0;
      r_timer   <= '0;
      r_pending <= '0;
      r_e       <= E_DONE;
    end else begin
      r_state   <= w_state_nx;
      r_dir     <= w_dir_nx;
      r_floor   <= w_floor_nx;
      r_timer   <= w_timer_nx;
      r_pending <= w_pending_nx;
      r_e       <= w_e_nx;
    end
  end

  assign E         = r_e;
  assign floor     = r_floor;
  assign moving    = (r_state == S_MOVE);
  assign door_open = (r_state == S_DOOR);
  assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_sequencer.sv
// Scoreboard bench for elevator_sequencer: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_elevator_sequencer;

  localparam int NF = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] req;
  logic [9:0]    E;
  logic [3:0]    floor;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;
`ifdef ELEV_ESTOP_EN
  logic          estop;
`endif

  elevator_sequencer #(
    .NUM_FLOORS(NF), .MID_FLOOR(4), .FLOOR_CYCLES(4), .DOOR_CYCLES(3), .MAX_PENDING(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef ELEV_ESTOP_EN
    .estop(estop),
`endif
    .E(E),
    .floor(floor),
    .moving(moving),
    .door_open(door_open),
    .pending(pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry: {cycle[15:0], E[9:0], floor[3:0], moving, door_open, pending[7:0]}
  logic [39:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic expect_at(input int c, input logic [9:0] e, input logic [3:0] f,
                           input logic mv, input logic dr, input logic [7:0] p);
    exp_q.push_back({16'(c), e, f, mv, dr, p});
  endtask

  always @(negedge clk) begin
    logic [39:0] ent;
    while (exp_q.size() > 0 && int'(exp_q[0][39:24]) <= cyc) begin
      ent = exp_q.pop_front();
      if (int'(ent[39:24]) != cyc) begin
        cmp("sched", 32'(ent[39:24]), 32'(cyc));
      end else begin
        cmp("E",         32'(E),         32'(ent[23:14]));
        cmp("floor",     32'(floor),     32'(ent[13:10]));
        cmp("moving",    32'(moving),    32'(ent[9]));
        cmp("door_open", 32'(door_open), 32'(ent[8]));
        cmp("pending",   32'(pending),   32'(ent[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int k, n, m, f;

  initial begin
    rst_n = 1'b0;
    req   = '0;
`ifdef ELEV_ESTOP_EN
    estop = 1'b0;
`endif

    // Idle after reset: DONE, floor 0, nothing pending, for 10 cycles
    do_reset();
    k = cyc;
    for (int c = k + 1; c <= k + 10; c++) expect_at(c, 10'h000, 4'd0, 1'b0, 1'b0, 8'h00);
    to_cyc(k + 10);

    // Single call to floor 3 from floor 0
    k = cyc;
    req = 8'h08;
    n = k + 1;
    expect_at(n, 10'h280, 4'd0, 1'b0, 1'b0, 8'h08);
    @(negedge clk);
    req = '0;
    for (int c = n + 1; c <= n + 12; c++) begin
      f = (c - n - 1) / 4;
      expect_at(c, 10'h280 | 10'(f), 4'(f), 1'b1, 1'b0, 8'h08);
    end
    for (int c = n + 13; c <= n + 15; c++) expect_at(c, 10'h2C3, 4'd3, 1'b0, 1'b1, 8'h00);
    expect_at(n + 16, 10'h000, 4'd3, 1'b0, 1'b0, 8'h00);
    to_cyc(n + 16);

    // Pass through the middle floor on the way to floor 6
    do_reset();
    k = cyc;
    req = 8'h40;
    n = k + 1;
    expect_at(n, 10'h280, 4'd0, 1'b0, 1'b0, 8'h40);
    @(negedge clk);
    req = '0;
    for (int c = n + 1; c <= n + 24; c++) begin
      f = (c - n - 1) / 4;
      expect_at(c, (f == 4) ? 10'h0F0 : (10'h280 | 10'(f)), 4'(f), 1'b1, 1'b0, 8'h40);
    end
    expect_at(n + 25, 10'h2C6, 4'd6, 1'b0, 1'b1, 8'h00);
    to_cyc(n + 26);

    // Asynchronous reset in the middle of a door cycle
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_E",       32'(E),         32'h000);
    cmp("async_floor",   32'(floor),     32'd0);
    cmp("async_moving",  32'(moving),    32'd0);
    cmp("async_door",    32'(door_open), 32'd0);
    cmp("async_pending", 32'(pending),   32'h00);

    // Capacity: park at floor 1, fill 6 floors, then two new calls are handed off
    do_reset();
    k = cyc;
    req = 8'h02;
    n = k + 1;
    expect_at(n, 10'h280, 4'd0, 1'b0, 1'b0, 8'h02);
    @(negedge clk);
    req = '0;
    expect_at(n + 1, 10'h280, 4'd0, 1'b1, 1'b0, 8'h02);
    for (int c = n + 5; c <= n + 7; c++) expect_at(c, 10'h2C1, 4'd1, 1'b0, 1'b1, 8'h00);
    expect_at(n + 8, 10'h000, 4'd1, 1'b0, 1'b0, 8'h00);
    to_cyc(n + 8);
    req = 8'h7D;
    m = n + 9;
    expect_at(m, 10'h281, 4'd1, 1'b0, 1'b0, 8'h7D);
    @(negedge clk);
    req = 8'h82;
    expect_at(m + 1, 10'h140, 4'd1, 1'b1, 1'b0, 8'h7D);
    for (int c = m + 2; c <= m + 4; c++) expect_at(c, 10'h281, 4'd1, 1'b1, 1'b0, 8'h7D);
    expect_at(m + 5, 10'h2C2, 4'd2, 1'b0, 1'b1, 8'h79);
    @(negedge clk);
    req = '0;
    // One slot free: floor 1 is accepted, floor 7 is handed off
    to_cyc(m + 5);
    req = 8'h82;
    expect_at(m + 6, 10'h140, 4'd2, 1'b0, 1'b1, 8'h7B);
    expect_at(m + 7, 10'h2C2, 4'd2, 1'b0, 1'b1, 8'h7B);
    expect_at(m + 8, 10'h282, 4'd2, 1'b0, 1'b0, 8'h7B);
    @(negedge clk);
    req = '0;
    to_cyc(m + 8);

    // Door hold: repeated call for the open floor keeps the door open
    do_reset();
    k = cyc;
    req = 8'h04;
    n = k + 1;
    expect_at(n, 10'h280, 4'd0, 1'b0, 1'b0, 8'h04);
    @(negedge clk);
    req = '0;
    for (int c = n + 9; c <= n + 16; c++) expect_at(c, 10'h2C2, 4'd2, 1'b0, 1'b1, 8'h00);
    expect_at(n + 17, 10'h000, 4'd2, 1'b0, 1'b0, 8'h00);
    to_cyc(n + 9);
    req = 8'h04;
    repeat (5) @(negedge clk);
    req = '0;
    to_cyc(n + 17);

`ifdef ELEV_ESTOP_EN
    // Emergency stop freezes the travel timer mid-floor
    do_reset();
    k = cyc;
    req = 8'h08;
    n = k + 1;
    expect_at(n, 10'h280, 4'd0, 1'b0, 1'b0, 8'h08);
    @(negedge clk);
    req = '0;
    to_cyc(n + 2);
    estop = 1'b1;
    for (int c = n + 3; c <= n + 9; c++) expect_at(c, 10'h3FF, 4'd0, 1'b1, 1'b0, 8'h08);
    expect_at(n + 10, 10'h280, 4'd0, 1'b1, 1'b0, 8'h08);
    expect_at(n + 11, 10'h280, 4'd0, 1'b1, 1'b0, 8'h08);
    expect_at(n + 12, 10'h281, 4'd1, 1'b1, 1'b0, 8'h08);
    to_cyc(n + 9);
    estop = 1'b0;
    to_cyc(n + 12);
`endif

    // ---------------- final report ----------------
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
